// File: rtl/sha2_msg_frontend.sv
// rtl/sha2_msg_frontend.sv - SHA-256 single-block message collector, padder and digest handshake
// Packs big-endian input words into one padded 512-bit block, strobes the core and returns its digest.
module sha2_msg_frontend #(
   parameter int N          = 32,
   parameter int WAIT_LIMIT = 80
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   in_data,
   input  logic [2:0]     in_bytes,
   input  logic           in_last,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [511:0]   msg_block,
   output logic           msg_strobe,
   input  logic [255:0]   core_hash,
   input  logic           core_valid,
   output logic [255:0]   hash_out,
   output logic           hash_valid,
   input  logic           hash_ready,
   output logic           err_len,
   output logic           err_timeout
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [2:0] {COLLECT, DROP, STROBE, WAIT, OUT} state_t;

   state_t        state;
   logic [5:0]    len;
   logic [CW-1:0] wait_cnt;
   logic [7:0]    data_buf [56];

   logic [7:0]    word_b [4];
   logic [7:0]    merged [56];
   logic [511:0]  padded;
   logic [2:0]    nbytes;
   logic [6:0]    total;

   assign word_b[0] = in_data[31:24];
   assign word_b[1] = in_data[23:16];
   assign word_b[2] = in_data[15:8];
   assign word_b[3] = in_data[7:0];

   // byte counts 4..7 all mean a full word
   assign nbytes = in_bytes[2] ? 3'd4 : in_bytes;
   assign total  = {1'b0, len} + {4'b0000, nbytes};

   always_comb begin
      padded = '0;
      for (int i = 0; i < 56; i++) begin
         merged[i] = data_buf[i];
         if (i >= int'(len) && i < int'(total)) begin
            merged[i] = word_b[2'(i - int'(len))];
         end
         if (i < int'(total)) begin
            padded[511 - 8*i -: 8] = merged[i];
         end else if (i == int'(total)) begin
            padded[511 - 8*i -: 8] = 8'h80;
         end
      end
      padded[63:0] = {54'd0, total, 3'b000};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= COLLECT;
         len         <= '0;
         wait_cnt    <= '0;
         for (int i = 0; i < 56; i++) data_buf[i] <= 8'h00;
         msg_block   <= '0;
         msg_strobe  <= 1'b0;
         hash_out    <= '0;
         hash_valid  <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         in_ready    <= 1'b0;
      end else begin
         msg_strobe  <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            COLLECT: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (in_last) begin
                     len <= '0;
                     if (total > 7'd55) begin
                        err_len <= 1'b1;
                     end else begin
                        msg_block  <= padded;
                        msg_strobe <= 1'b1;
                        in_ready   <= 1'b0;
                        state      <= STROBE;
                     end
                  end else if (total > 7'd55) begin
                     len   <= '0;
                     state <= DROP;
                  end else begin
                     data_buf <= merged;
                     len      <= total[5:0];
                  end
               end
            end
            DROP: begin
               if (in_valid && in_last) begin
                  err_len <= 1'b1;
                  len     <= '0;
                  state   <= COLLECT;
               end
            end
            STROBE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (core_valid) begin
                  hash_out   <= core_hash;
                  hash_valid <= 1'b1;
                  state      <= OUT;
               end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                  err_timeout <= 1'b1;
                  in_ready    <= 1'b1;
                  len         <= '0;
                  state       <= COLLECT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            OUT: begin
               if (hash_ready) begin
                  hash_valid <= 1'b0;
                  in_ready   <= 1'b1;
                  len        <= '0;
                  state      <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_sha2_msg_frontend.sv
// tb/tb_sha2_msg_frontend.sv - directed scoreboard bench for sha2_msg_frontend
// A behavioural core stub answers 64 cycles after each strobe with a digest chosen from the block.
module tb_sha2_msg_frontend;
   localparam int WAIT_LIMIT = 80;
   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   in_data = '0;
   logic [2:0]    in_bytes = '0;
   logic          in_last = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [511:0]  msg_block;
   logic          msg_strobe;
   logic [255:0]  core_hash = '0;
   logic          core_valid;
   logic [255:0]  hash_out;
   logic          hash_valid;
   logic          hash_ready = 1'b0;
   logic          err_len;
   logic          err_timeout;

   logic          stub_on = 1'b1;
   logic          stub_valid = 1'b0;
   logic          manual_cv = 1'b0;
   int            stub_cnt = 0;

   int checks = 0;
   int errors = 0;
   int n_strobe = 0, n_err_len = 0, n_err_to = 0, n_both = 0;

   logic [511:0] exp_blk_q [$];
   logic [255:0] exp_hash_q [$];
   logic [7:0]   msg_q [$];

   always #5 clk = ~clk;

   sha2_msg_frontend #(.N(32), .WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready),
      .msg_block(msg_block), .msg_strobe(msg_strobe),
      .core_hash(core_hash), .core_valid(core_valid),
      .hash_out(hash_out), .hash_valid(hash_valid), .hash_ready(hash_ready),
      .err_len(err_len), .err_timeout(err_timeout)
   );

   function automatic logic [255:0] hash_of(input logic [511:0] b);
      if (b == ABC_BLK) return ABC_H;
      if (b == EMPTY_BLK) return EMPTY_H;
      return b[511:256] ^ b[255:0];
   endfunction

   // core stub: latches the digest at the strobe, answers 64 cycles later, keeps counting through reset
   always @(posedge clk) begin
      stub_valid <= 1'b0;
      if (msg_strobe && stub_on) begin
         stub_cnt  <= 63;
         core_hash <= hash_of(msg_block);
      end else if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) stub_valid <= 1'b1;
      end
   end
   assign core_valid = stub_valid | manual_cv;

   always @(posedge clk) begin
      if (msg_strobe) n_strobe <= n_strobe + 1;
      if (err_len) n_err_len <= n_err_len + 1;
      if (err_timeout) n_err_to <= n_err_to + 1;
      if (err_len && err_timeout) n_both <= n_both + 1;
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] build_block();
      logic [511:0] b = '0;
      int n = msg_q.size();
      for (int i = 0; i < n; i++) b[511 - 8*i -: 8] = msg_q[i];
      b[511 - 8*n -: 8] = 8'h80;
      b[63:0] = 64'(n * 8);
      return b;
   endfunction

   task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
      int t = 0;
      in_data = d; in_bytes = nb; in_last = last; in_valid = 1'b1;
      while (!in_ready && t < 20) begin @(negedge clk); t++; end
      check("in_ready_accept", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_msg();
      int n = msg_q.size();
      int nw = (n + 3) / 4;
      if (n == 0) send_word(32'h0, 3'd0, 1'b1);
      for (int w = 0; w < nw; w++) begin
         logic [31:0] d = '0;
         int nb = (n - 4*w >= 4) ? 4 : n - 4*w;
         for (int j = 0; j < nb; j++) d[31 - 8*j -: 8] = msg_q[4*w + j];
         send_word(d, 3'(nb), w == nw - 1);
      end
   endtask

   task automatic wait_strobe();
      int t = 0;
      while (!msg_strobe && t < 20) begin @(negedge clk); t++; end
      check("strobe_seen", msg_strobe, 1);
      check("msg_block", msg_block, exp_blk_q.pop_front());
   endtask

   task automatic finish_hash(input int hold, input bit early);
      int t = 0;
      logic [255:0] eh;
      eh = exp_hash_q.pop_front();
      if (early) hash_ready = 1'b1;
      while (!hash_valid && t < 100) begin @(negedge clk); t++; end
      check("hash_valid", hash_valid, 1);
      check("hash_out", hash_out, eh);
      if (!early) begin
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_hash_out", hash_out, eh);
            check("hold_in_ready", in_ready, 0);
            check("hold_hash_valid", hash_valid, 1);
         end
         hash_ready = 1'b1;
      end
      @(negedge clk);
      hash_ready = 1'b0;
      check("post_hash_valid", hash_valid, 0);
      check("post_in_ready", in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s0, e0, t0, k;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_msg_block", msg_block, 0);
      check("rst_hash_out", hash_out, 0);
      check("rst_flags", {hash_valid, msg_strobe, err_len, err_timeout}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);

      // "abc"
      msg_q = '{8'h61, 8'h62, 8'h63};
      exp_blk_q.push_back(ABC_BLK); exp_hash_q.push_back(ABC_H);
      send_msg(); wait_strobe();
      @(negedge clk);
      check("wait_in_ready", in_ready, 0);
      check("wait_strobe_low", msg_strobe, 0);
      finish_hash(0, 0);

      // stray core_valid while idle
      manual_cv = 1'b1; @(negedge clk); manual_cv = 1'b0; @(negedge clk);
      check("stray_cv_hash_valid", hash_valid, 0);
      check("stray_cv_in_ready", in_ready, 1);

      // empty message, ready already high on OUT entry
      exp_blk_q.push_back(EMPTY_BLK); exp_hash_q.push_back(EMPTY_H);
      send_word(32'h0, 3'd0, 1'b1); wait_strobe();
      finish_hash(0, 1);

      // 55 bytes, hash_ready held off for 10 cycles
      msg_q.delete();
      for (int i = 0; i < 55; i++) msg_q.push_back(8'(i + 1));
      exp_blk_q.push_back(build_block()); exp_hash_q.push_back(hash_of(build_block()));
      s0 = n_strobe;
      send_msg(); wait_strobe();
      check("b55_byte55", msg_block[71:0], {8'h80, 64'h1b8});
      finish_hash(10, 0);
      check("b55_one_strobe", n_strobe - s0, 1);

      // 56 bytes: overflow on the last word
      msg_q.delete();
      for (int i = 0; i < 56; i++) msg_q.push_back(8'(8'hA0 + i));
      s0 = n_strobe; e0 = n_err_len;
      send_msg(); repeat (3) @(negedge clk);
      check("b56_err_len", n_err_len - e0, 1);
      check("b56_no_strobe", n_strobe - s0, 0);
      check("b56_in_ready", in_ready, 1);
      msg_q = '{8'h61, 8'h62, 8'h63};
      exp_blk_q.push_back(ABC_BLK); exp_hash_q.push_back(ABC_H);
      send_msg(); wait_strobe(); finish_hash(0, 0);

      // 60 bytes: overflow on a non-last word goes through DROP
      msg_q.delete();
      for (int i = 0; i < 60; i++) msg_q.push_back(8'(i * 3));
      s0 = n_strobe; e0 = n_err_len;
      send_msg(); repeat (3) @(negedge clk);
      check("b60_err_len", n_err_len - e0, 1);
      check("b60_no_strobe", n_strobe - s0, 0);

      // in_bytes=7 counts as a full word
      exp_blk_q.push_back({32'hdeadbeef, 8'h80, 408'h0, 64'd32});
      exp_hash_q.push_back(hash_of({32'hdeadbeef, 8'h80, 408'h0, 64'd32}));
      send_word(32'hdeadbeef, 3'd7, 1'b1); wait_strobe(); finish_hash(0, 0);

      // core never answers
      stub_on = 1'b0;
      msg_q = '{8'h11};
      exp_blk_q.push_back(build_block());
      t0 = n_err_to;
      send_msg(); wait_strobe();
      k = 0;
      while (!err_timeout && k < 200) begin @(negedge clk); k++; end
      check("timeout_latency", k, WAIT_LIMIT + 1);
      check("timeout_in_ready", in_ready, 1);
      check("timeout_hash_valid", hash_valid, 0);
      @(negedge clk);
      check("timeout_one_pulse", n_err_to - t0, 1);
      stub_on = 1'b1;

      // reset mid-WAIT, core answers after release
      msg_q = '{8'h61, 8'h62, 8'h63};
      exp_blk_q.push_back(ABC_BLK);
      send_msg(); wait_strobe();
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_msg_block", msg_block, 0);
      check("mid_rst_hash_out", hash_out, 0);
      check("mid_rst_flags", {hash_valid, msg_strobe, err_len, err_timeout}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      t0 = n_err_to;
      repeat (70) @(negedge clk);
      check("late_cv_hash_valid", hash_valid, 0);
      check("late_cv_hash_out", hash_out, 0);
      check("late_cv_in_ready", in_ready, 1);
      check("late_cv_no_timeout", n_err_to - t0, 0);

      check("errors_exclusive", n_both, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
